// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frame loader behind the UART byte receiver.
// Hunts for a sync byte, reads a 16-bit little-endian length, streams the
// payload into a byte-wide buffer and verifies a modulo-256 checksum.
module uart_rx_frame_ctrl #(
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 100000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_rx_done_tick,
    input  logic [7:0]        i_rx_dout,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_frame_err,
    output logic [1:0]        o_err_code,
    output logic [ADDR_W-1:0] o_frame_len
);

    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [15:0]     LEN_MAX = 16'((2 ** ADDR_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_LEN_LO  = 3'd2,
        S_LEN_HI  = 3'd3,
        S_PAYLOAD = 3'd4,
        S_CHECK   = 3'd5
    } state_t;

    state_t              r_state,    w_state;
    logic [7:0]          r_lenLo,    w_lenLo;
    logic [ADDR_W-1:0]   r_idx,      w_idx;
    logic [7:0]          r_csum,     w_csum;
    logic [TW-1:0]       r_tcnt,     w_tcnt;
    logic                r_memWe,    w_memWe;
    logic [ADDR_W-1:0]   r_memAddr,  w_memAddr;
    logic [7:0]          r_memWdata, w_memWdata;
    logic                r_busy,     w_busy;
    logic                r_done,     w_done;
    logic                r_err,      w_err;
    logic [1:0]          r_errCode,  w_errCode;
    logic [ADDR_W-1:0]   r_frameLen, w_frameLen;
    logic [15:0]         w_len16;

    // Next-state and next-output logic; a strobe always beats the timeout, and enable low overrides everything.
    always_comb begin
        w_state    = r_state;
        w_lenLo    = r_lenLo;
        w_idx      = r_idx;
        w_csum     = r_csum;
        w_tcnt     = r_tcnt;
        w_memWe    = 1'b0;
        w_memAddr  = r_memAddr;
        w_memWdata = r_memWdata;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_errCode  = r_errCode;
        w_frameLen = r_frameLen;
        w_len16    = {i_rx_dout, r_lenLo};

        if (!i_enable) begin
            w_state = S_IDLE;
            w_tcnt  = '0;
        end else if (r_state == S_IDLE) begin
            w_state = S_SYNC;
            w_tcnt  = '0;
        end else if (r_state == S_SYNC) begin
            w_tcnt = '0;
            if (i_rx_done_tick && (i_rx_dout == SYNC_BYTE)) begin
                w_state   = S_LEN_LO;
                w_errCode = 2'd0;
                w_csum    = 8'd0;
            end
        end else if (!i_rx_done_tick) begin
            if (r_tcnt == T_LAST) begin
                w_err     = 1'b1;
                w_errCode = 2'd2;
                w_state   = S_SYNC;
                w_tcnt    = '0;
            end else begin
                w_tcnt = r_tcnt + 1'b1;
            end
        end else begin
            w_tcnt = '0;
            case (r_state)
                S_LEN_LO: begin
                    w_lenLo = i_rx_dout;
                    w_state = S_LEN_HI;
                end
                S_LEN_HI: begin
                    if (w_len16 > LEN_MAX) begin
                        w_err     = 1'b1;
                        w_errCode = 2'd3;
                        w_state   = S_SYNC;
                    end else begin
                        w_frameLen = w_len16[ADDR_W-1:0];
                        w_idx      = '0;
                        w_state    = (w_len16 == 16'd0) ? S_CHECK : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    w_memWe    = 1'b1;
                    w_memAddr  = r_idx;
                    w_memWdata = i_rx_dout;
                    w_csum     = r_csum + i_rx_dout;
                    w_idx      = r_idx + 1'b1;
                    if (r_idx == (r_frameLen - 1'b1)) begin
                        w_state = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (i_rx_dout == r_csum) begin
                        w_done = 1'b1;
                    end else begin
                        w_err     = 1'b1;
                        w_errCode = 2'd1;
                    end
                    w_state = S_SYNC;
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end

        w_busy = (w_state == S_LEN_LO) || (w_state == S_LEN_HI) ||
                 (w_state == S_PAYLOAD) || (w_state == S_CHECK);
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_lenLo    <= '0;
            r_idx      <= '0;
            r_csum     <= '0;
            r_tcnt     <= '0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_errCode  <= '0;
            r_frameLen <= '0;
        end else begin
            r_state    <= w_state;
            r_lenLo    <= w_lenLo;
            r_idx      <= w_idx;
            r_csum     <= w_csum;
            r_tcnt     <= w_tcnt;
            r_memWe    <= w_memWe;
            r_memAddr  <= w_memAddr;
            r_memWdata <= w_memWdata;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
            r_errCode  <= w_errCode;
            r_frameLen <= w_frameLen;
        end
    end

    assign o_mem_we     = r_memWe;
    assign o_mem_addr   = r_memAddr;
    assign o_mem_wdata  = r_memWdata;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;
    assign o_frame_err  = r_err;
    assign o_err_code   = r_errCode;
    assign o_frame_len  = r_frameLen;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a small address width and short timeout.
module tb_uart_rx_frame_ctrl;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 50;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              rxDoneTick;
    logic [7:0]        rxDout;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [7:0]        memWdata;
    logic              busy;
    logic              frameDone;
    logic              frameErr;
    logic [1:0]        errCode;
    logic [ADDR_W-1:0] frameLen;

    int checks = 0;
    int errors = 0;
    int writeCount = 0;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(
        .ADDR_W   (ADDR_W),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_enable      (enable),
        .i_rx_done_tick(rxDoneTick),
        .i_rx_dout     (rxDout),
        .o_mem_we      (memWe),
        .o_mem_addr    (memAddr),
        .o_mem_wdata   (memWdata),
        .o_busy        (busy),
        .o_frame_done  (frameDone),
        .o_frame_err   (frameErr),
        .o_err_code    (errCode),
        .o_frame_len   (frameLen)
    );

    // Count buffer writes shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (memWe === 1'b1) writeCount++;
    end

    // Hard stop in case the run wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One strobe sampled on the next rising edge; consecutive calls give back-to-back strobes.
    task automatic applyStimulus(input logic [7:0] b);
        rxDoneTick = 1'b1;
        rxDout     = b;
        @(negedge clk);
        rxDoneTick = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_we"},   32'(memWe),     32'h0);
        checkOutput({tag, "_addr"}, 32'(memAddr),   32'h0);
        checkOutput({tag, "_data"}, 32'(memWdata),  32'h0);
        checkOutput({tag, "_busy"}, 32'(busy),      32'h0);
        checkOutput({tag, "_done"}, 32'(frameDone), 32'h0);
        checkOutput({tag, "_err"},  32'(frameErr),  32'h0);
        checkOutput({tag, "_code"}, 32'(errCode),   32'h0);
        checkOutput({tag, "_len"},  32'(frameLen),  32'h0);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        rxDoneTick = 1'b0;
        rxDout     = 8'h00;
        idleCycles(2);
        checkAllZero("reset");
        reset  = 1'b0;
        enable = 1'b1;
        idleCycles(1);
        checkOutput("idleBusy", 32'(busy), 32'h0);

        // Good frame A5 03 00 10 20 30 60
        applyStimulus(8'hA5);
        checkOutput("g_syncBusy", 32'(busy), 32'h1);
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        checkOutput("g_len", 32'(frameLen), 32'h3);
        checkOutput("g_lenNoWe", 32'(memWe), 32'h0);
        applyStimulus(8'h10);
        checkOutput("g_we0", 32'(memWe), 32'h1);
        checkOutput("g_addr0", 32'(memAddr), 32'h0);
        checkOutput("g_data0", 32'(memWdata), 32'h10);
        applyStimulus(8'h20);
        checkOutput("g_addr1", 32'(memAddr), 32'h1);
        checkOutput("g_data1", 32'(memWdata), 32'h20);
        applyStimulus(8'h30);
        checkOutput("g_addr2", 32'(memAddr), 32'h2);
        checkOutput("g_data2", 32'(memWdata), 32'h30);
        applyStimulus(8'h60);
        checkOutput("g_done", 32'(frameDone), 32'h1);
        checkOutput("g_noErr", 32'(frameErr), 32'h0);
        checkOutput("g_noWe", 32'(memWe), 32'h0);
        checkOutput("g_addrHold", 32'(memAddr), 32'h2);
        checkOutput("g_busyLow", 32'(busy), 32'h0);
        checkOutput("g_code", 32'(errCode), 32'h0);
        idleCycles(1);
        checkOutput("g_donePulse", 32'(frameDone), 32'h0);
        checkOutput("g_writes", 32'(writeCount), 32'd3);

        // Bad checksum A5 02 00 01 02 04
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h04);
        checkOutput("b_err", 32'(frameErr), 32'h1);
        checkOutput("b_done", 32'(frameDone), 32'h0);
        checkOutput("b_code", 32'(errCode), 32'h1);
        checkOutput("b_writes", 32'(writeCount), 32'd5);

        // Resync: FF 11 ignored, then A5 01 00 7F 7F
        applyStimulus(8'hFF);
        applyStimulus(8'h11);
        checkOutput("r_ignBusy", 32'(busy), 32'h0);
        checkOutput("r_codeHeld", 32'(errCode), 32'h1);
        checkOutput("r_errPulse", 32'(frameErr), 32'h0);
        applyStimulus(8'hA5);
        checkOutput("r_codeClr", 32'(errCode), 32'h0);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h7F);
        checkOutput("r_addr0", 32'(memAddr), 32'h0);
        checkOutput("r_data0", 32'(memWdata), 32'h7F);
        applyStimulus(8'h7F);
        checkOutput("r_done", 32'(frameDone), 32'h1);
        checkOutput("r_writes", 32'(writeCount), 32'd6);

        // Zero length A5 00 00 00
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        checkOutput("z_len", 32'(frameLen), 32'h0);
        checkOutput("z_busy", 32'(busy), 32'h1);
        applyStimulus(8'h00);
        checkOutput("z_done", 32'(frameDone), 32'h1);
        checkOutput("z_writes", 32'(writeCount), 32'd6);

        // Sync value as payload A5 01 00 A5 A5
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'hA5);
        checkOutput("s_we", 32'(memWe), 32'h1);
        checkOutput("s_data", 32'(memWdata), 32'hA5);
        applyStimulus(8'hA5);
        checkOutput("s_done", 32'(frameDone), 32'h1);

        // Timeout: A5 04 00 01 then silence
        applyStimulus(8'hA5);
        applyStimulus(8'h04);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        checkOutput("t_writes", 32'(writeCount), 32'd8);
        for (int k = 1; k < TIMEOUT; k++) begin
            idleCycles(1);
            checkOutput("t_noEarlyErr", 32'(frameErr), 32'h0);
        end
        checkOutput("t_busyBefore", 32'(busy), 32'h1);
        idleCycles(1);
        checkOutput("t_err", 32'(frameErr), 32'h1);
        checkOutput("t_code", 32'(errCode), 32'h2);
        checkOutput("t_busy", 32'(busy), 32'h0);
        idleCycles(1);
        checkOutput("t_errPulse", 32'(frameErr), 32'h0);

        // Strobe on the expiry cycle wins: A5 02 00 11 ... 22 33
        applyStimulus(8'hA5);
        checkOutput("p_codeClr", 32'(errCode), 32'h0);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h11);
        idleCycles(TIMEOUT - 1);
        applyStimulus(8'h22);
        checkOutput("p_noErr", 32'(frameErr), 32'h0);
        checkOutput("p_we", 32'(memWe), 32'h1);
        checkOutput("p_addr", 32'(memAddr), 32'h1);
        checkOutput("p_data", 32'(memWdata), 32'h22);
        applyStimulus(8'h33);
        checkOutput("p_done", 32'(frameDone), 32'h1);
        checkOutput("p_writes", 32'(writeCount), 32'd10);

        // Length overflow: A5 00 01 with ADDR_W=8
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        checkOutput("o_err", 32'(frameErr), 32'h1);
        checkOutput("o_code", 32'(errCode), 32'h3);
        checkOutput("o_busy", 32'(busy), 32'h0);
        checkOutput("o_lenHeld", 32'(frameLen), 32'h2);
        idleCycles(1);
        checkOutput("o_writes", 32'(writeCount), 32'd10);

        // Abort: drop enable after 2 payload bytes of a 5-byte frame
        applyStimulus(8'hA5);
        applyStimulus(8'h05);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        enable = 1'b0;
        applyStimulus(8'h03);
        checkOutput("a_busy", 32'(busy), 32'h0);
        checkOutput("a_we", 32'(memWe), 32'h0);
        checkOutput("a_done", 32'(frameDone), 32'h0);
        checkOutput("a_err", 32'(frameErr), 32'h0);
        checkOutput("a_lenHeld", 32'(frameLen), 32'h5);
        applyStimulus(8'h04);
        idleCycles(1);
        checkOutput("a_writes", 32'(writeCount), 32'd12);
        enable = 1'b1;
        idleCycles(1);
        applyStimulus(8'h03);
        checkOutput("a_syncIgnore", 32'(busy), 32'h0);

        // Reset mid-payload, then a full frame A5 02 00 05 06 0B
        applyStimulus(8'hA5);
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("rst");
        @(negedge clk);
        reset = 1'b0;
        idleCycles(1);
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h05);
        applyStimulus(8'h06);
        checkOutput("x_addr1", 32'(memAddr), 32'h1);
        applyStimulus(8'h0B);
        checkOutput("x_done", 32'(frameDone), 32'h1);
        checkOutput("x_len", 32'(frameLen), 32'h2);
        checkOutput("x_writes", 32'(writeCount), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame controller downstream of the UART byte receiver. It consumes the receiver's byte strobe and data, hunts for a sync byte, and reads a 16-bit little-endian length. It then sequences the payload bytes into a byte-wide buffer memory, checks a modulo-256 checksum, and reports done or error. It is the loader that fills the image/weight buffer over the UART link.

Parameters:
ADDR_W, 16, buffer address width; maximum payload length is 2^ADDR_W - 1 bytes
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 100000, clk cycles allowed between bytes inside a frame before abort

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = accept frames; 0 = abort any frame and hold in IDLE
rx_done_tick  input  1  one-cycle strobe from the receiver: rx_dout is valid
rx_dout  input  8  received byte
mem_we  output  1  buffer write strobe, one cycle per payload byte
mem_addr  output  ADDR_W  buffer write address, payload index starting at 0
mem_wdata  output  8  buffer write data
busy  output  1  high in LEN_LO, LEN_HI, PAYLOAD and CHECK
frame_done  output  1  one-cycle pulse: frame received with a good checksum
frame_err  output  1  one-cycle pulse: frame aborted
err_code  output  2  0 none, 1 checksum, 2 timeout, 3 length overflow; held until the next sync byte is accepted
frame_len  output  ADDR_W  length of the last accepted length field; held

Behaviour:
- Reset: state=IDLE; all outputs 0, including mem_we, mem_addr, mem_wdata, busy, pulses, err_code and frame_len. Internal counters and the checksum accumulator are 0.
- All outputs are registered. Every action happens on the clk edge where rx_done_tick=1, and its result is visible the next cycle (latency 1).
- States:
  - IDLE: if enable=1, go to SYNC.
  - SYNC: on a byte equal to SYNC_BYTE, go to LEN_LO, clear err_code, the checksum and the timeout counter. Any other byte is discarded.
  - LEN_LO: the byte becomes len[7:0]; go to LEN_HI.
  - LEN_HI: the byte becomes len[15:8].
    - If ADDR_W<16 and len >= 2^ADDR_W, pulse frame_err with err_code=3 and go to SYNC.
    - Otherwise load frame_len=len and idx=0. If len==0 go to CHECK, else go to PAYLOAD.
  - PAYLOAD: for each byte, mem_we=1 for one cycle with mem_addr=idx and mem_wdata=byte. Add the byte to the checksum (8-bit wrap) and increment idx. After the byte with idx==len-1, go to CHECK.
  - CHECK: if the byte equals the checksum, pulse frame_done. Otherwise pulse frame_err with err_code=1. Either way go to SYNC.
- mem_addr holds its last value when mem_we=0.
- Timeout:
  - A counter runs in LEN_LO, LEN_HI, PAYLOAD and CHECK, and clears on every rx_done_tick.
  - When it reaches TIMEOUT-1 with no strobe, pulse frame_err with err_code=2 and go to SYNC.
  - If a strobe arrives in the same cycle, the strobe wins and there is no timeout.
- enable=0 in any state: go to IDLE next cycle. There is no done or error pulse and no further mem_we; err_code and frame_len hold.
- A strobe in the same cycle that enable falls is ignored.
- The frame_done and frame_err pulses are mutually exclusive and never last longer than one cycle.
- Back-to-back strobes on consecutive cycles must be handled. Each produces exactly one action, with no lost bytes.
- Asserting reset mid-frame clears everything immediately (asynchronously). Memory contents are not touched.
- Only SYNC_BYTE in SYNC starts a frame. Inside a frame, 8'hA5 is ordinary data.

Test Plan:
- Good frame: with enable=1, send A5 03 00 10 20 30 60. Required: three mem_we pulses writing addr0=10, addr1=20, addr2=30; then frame_done one cycle after the last strobe; frame_len=3; err_code=0.
- Bad checksum and resync: send A5 02 00 01 02 04. Required: 2 writes, frame_err with err_code=1. Then send FF 11 A5 01 00 7F 7F. Required: FF and 11 are ignored, addr0=7F is written, frame_done fires, and err_code clears to 0 on the A5.
- Zero length and in-frame sync value: send A5 00 00 00. Required: no mem_we and frame_done. Then send A5 01 00 A5 A5. Required: addr0=A5 is written and frame_done fires.
- Timeout (TIMEOUT=50): send A5 04 00 01, then stay idle. Required: frame_err with err_code=2 exactly 50 cycles after the 01 strobe, and state back to SYNC. Also, a strobe arriving on cycle 49 must prevent the timeout.
- Overflow (ADDR_W=8): send A5 00 01. Required: frame_err with err_code=3 and no mem_we.
- Abort and reset: drop enable after 2 payload bytes of a 5-byte frame. Required: no pulses, no further writes, busy=0 next cycle. Separately, assert reset mid-PAYLOAD. Required: all outputs 0 immediately, and a full frame succeeds after reset is released.
